// File: rtl/vfifo_dpram_port_arbiter.sv
// Round-robin arbiter that shares one port of the dual-port FIFO RAM among N_REQ requesters.
// It registers the winning command onto the RAM port and routes read data back with a per-requester valid.
module vfifo_dpram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int N_REQ      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_adr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_d,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]         ram_adr,
    output logic [DATA_WIDTH-1:0]         ram_d,
    output logic                          ram_we,
    input  logic [DATA_WIDTH-1:0]         ram_q,
    output logic                          busy
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        grant_id;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] adr_arr [N_REQ];
    logic [DATA_WIDTH-1:0] d_arr   [N_REQ];
    logic                  s1_valid;
    logic                  s2_valid;
    logic [IDW-1:0]        s1_id;
    logic [IDW-1:0]        s2_id;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign adr_arr[g] = req_adr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign d_arr[g]   = req_d[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last winner, so the previous grantee has lowest priority.
    always_comb begin
        int idx;
        ack      = '0;
        grant    = 1'b0;
        grant_id = '0;
        idx      = 0;
        if (rst_n && en) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!grant && req[idx]) begin
                    grant    = 1'b1;
                    grant_id = IDW'(idx);
                end
            end
            if (grant) ack[grant_id] = 1'b1;
        end
    end

    // Command register plus a two-stage {valid,id} tag that tracks the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= IDW'(N_REQ - 1);
            ram_we   <= 1'b0;
            ram_adr  <= '0;
            ram_d    <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
        end else begin
            ram_we   <= grant & req_we[grant_id];
            s1_valid <= grant & ~req_we[grant_id];
            s1_id    <= grant_id;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            if (grant) begin
                ptr     <= grant_id;
                ram_adr <= adr_arr[grant_id];
                ram_d   <= d_arr[grant_id];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (s2_valid) rd_valid[s2_id] = 1'b1;
    end

    assign rd_data = ram_q;
    assign busy    = s1_valid | s2_valid;

endmodule

// File: tb/tb_vfifo_dpram_port_arbiter.sv
// Self-checking bench for vfifo_dpram_port_arbiter with a behavioural RAM on the shared port.
// A scoreboard queues expected read returns on every read grant and checks them as rd_valid fires.
module tb_vfifo_dpram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_adr;
    logic [NR*DW-1:0]  req_d;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     rd_valid;
    logic [DW-1:0]     rd_data;
    logic [AW-1:0]     ram_adr;
    logic [DW-1:0]     ram_d;
    logic              ram_we;
    logic [DW-1:0]     ram_q;
    logic              busy;

    logic [DW-1:0]     mem    [1<<AW];
    logic [DW-1:0]     shadow [1<<AW];

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    vfifo_dpram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_we(req_we),
        .req_adr(req_adr), .req_d(req_d), .ack(ack), .rd_valid(rd_valid),
        .rd_data(rd_data), .ram_adr(ram_adr), .ram_d(ram_d), .ram_we(ram_we),
        .ram_q(ram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM model: registered output, old data on a same-edge read-during-write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_adr] <= ram_d;
        ram_q <= mem[ram_adr];
    end

    // Scoreboard: push on read grants, pop and compare when rd_valid fires.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (rd_valid != '0) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_unexpected rd_valid=%b rd_data=%h required no return", rd_valid, rd_data);
                end else begin
                    e = sb_q.pop_front();
                    if (rd_valid !== (NR'(1) << e.id) || rd_data !== e.data || cyc !== e.cyc + 2) begin
                        bad++;
                        $display("[TB] FAIL sb_return rd_valid=%b data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                                 rd_valid, rd_data, cyc, e.id, e.data, e.cyc + 2);
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req[i] && ack[i]) begin
                    if (req_we[i]) begin
                        shadow[req_adr[i*AW +: AW]] = req_d[i*DW +: DW];
                    end else begin
                        e.id   = i;
                        e.data = shadow[req_adr[i*AW +: AW]];
                        e.cyc  = cyc;
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'hF;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (ack !== 4'b0000 || ram_we !== 1'b0 || rd_valid !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_outputs ack=%b ram_we=%b rd_valid=%b busy=%b required 0", ack, ram_we, rd_valid, busy);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL reset_first_ack ack=%b required 0001", ack);
        end
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        req = 4'b0001; req_we[0] = 1'b1;
        req_adr[0*AW +: AW] = 9'h005; req_d[0*DW +: DW] = 8'hA5;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL wr_ack ack=%b required 0001", ack);
        end
        @(posedge clk); #1;
        req_we[0] = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL rd_ack ack=%b required 0001", ack);
        end
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rd_valid !== 4'b0001 || rd_data !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL wr_then_rd rd_valid=%b rd_data=%h required 0001 a5", rd_valid, rd_data);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_ack;
        @(posedge clk); #1;
        req = 4'b1000; req_we = '0; req_adr[3*AW +: AW] = 9'h033;
        @(negedge clk);
        total++;
        if (ack !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL rr_setup ack=%b required 1000", ack);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) req_adr[i*AW +: AW] = AW'(9'h010 + i);
        req = 4'hF;
        for (int i = 0; i < NR; i++) begin
            exp_ack = NR'(1) << i;
            @(negedge clk);
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("[TB] FAIL rr_order step=%0d ack=%b required %b", i, ack, exp_ack);
            end
            @(posedge clk); #1;
            req[i] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_ack;
        @(posedge clk); #1;
        req_adr[0*AW +: AW] = 9'h020;
        req_adr[2*AW +: AW] = 9'h022;
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            exp_ack = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            @(negedge clk);
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("[TB] FAIL fair_alt step=%0d ack=%b required %b", k, ack, exp_ack);
            end
            @(posedge clk); #1;
        end
        req = '0;
    endtask

    task automatic test_enable();
        @(posedge clk); #1;
        en = 1'b0;
        req = 4'b0010; req_we[1] = 1'b1;
        req_adr[1*AW +: AW] = 9'h040; req_d[1*DW +: DW] = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (ack !== 4'b0000 || ram_we !== 1'b0) begin
                bad++;
                $display("[TB] FAIL en_off ack=%b ram_we=%b required 0000 0", ack, ram_we);
            end
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL en_on ack=%b required 0010", ack);
        end
        @(posedge clk); #1;
        req_we[1] = 1'b0;
        @(negedge clk);
        total++;
        if (ram_we !== 1'b1 || ram_adr !== 9'h040 || ram_d !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL en_cmd ram_we=%b ram_adr=%h ram_d=%h required 1 040 3c", ram_we, ram_adr, ram_d);
        end
        @(posedge clk); #1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_flush();
        @(posedge clk); #1;
        req = 4'b0001; req_we[0] = 1'b0; req_adr[0*AW +: AW] = 9'h007;
        @(negedge clk);
        total++;
        if (ack !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL flush_ack ack=%b required 0001", ack);
        end
        @(posedge clk); #1;
        req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_busy_inflight busy=%b required 1", busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (rd_valid !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL flush_discard rd_valid=%b busy=%b required 0000 0", rd_valid, busy);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]    = DW'(a * 7 + 3);
            shadow[a] = DW'(a * 7 + 3);
        end
        rst_n   = 1'b0;
        en      = 1'b1;
        req     = '0;
        req_we  = '0;
        req_adr = '0;
        req_d   = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_enable();
        test_reset_flush();
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_drain pending=%0d required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
